dat_mem_arb: RTL

- Two-port arbiter and sequencer for the single-port 8-bit x 256 data memory.
- Port 0 is the core load/store unit; port 1 is the loader/DMA (test-vector init, result dump).
- Each cycle, grants at most one requester and drives the memory's address, data, rd_en and wr_en.
- Registers read data back to the winner, and supports a bounded lock for atomic read-modify-write sequences.

---
 rtl/dat_mem_arb_if.sv | 48 ++++
 rtl/dat_mem_arb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dat_mem_arb_if.sv
// Requester and memory-side signal bundle for dat_mem_arb.
// slave: the arbiter's view; master: the requesters plus memory model driving it.
interface dat_mem_arb_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          p0_req;
    logic          p0_we;
    logic          p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic          p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_din, mem_rd_en, mem_wr_en,
        input  mem_dout
    );

    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_din, mem_rd_en, mem_wr_en,
        output mem_dout
    );
endinterface

// File: rtl/dat_mem_arb.sv
// Two-port round-robin arbiter with bounded lock for a single-port data memory.
// Optional conflict counter enabled by defining DAT_MEM_ARB_STATS_EN.
module dat_mem_arb #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic         clk,
    input  logic         reset,
    dat_mem_arb_if.slave bus,
    output logic [15:0]  conflict_cnt
);
    localparam int unsigned   CW         = 4;
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_rr_last;
    logic [CW-1:0] r_lock_cnt;
    logic          r_p0_rvalid;
    logic          r_p1_rvalid;
    logic [DW-1:0] r_p0_rdata;
    logic [DW-1:0] r_p1_rdata;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_we;
    logic          w_lock;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Grant decision; r_rr_last holds the index of the previous winner.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ARB: begin
                    if (bus.p0_req && bus.p1_req) begin
                        w_gnt0 = r_rr_last;
                        w_gnt1 = !r_rr_last;
                    end else begin
                        w_gnt0 = bus.p0_req;
                        w_gnt1 = bus.p1_req;
                    end
                end
                LOCK0:   w_gnt0 = bus.p0_req;
                LOCK1:   w_gnt1 = bus.p1_req;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_lock  = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_we    = bus.p0_we;
            w_lock  = bus.p0_lock;
            w_addr  = bus.p0_addr;
            w_wdata = bus.p0_wdata;
        end else if (w_gnt1) begin
            w_we    = bus.p1_we;
            w_lock  = bus.p1_lock;
            w_addr  = bus.p1_addr;
            w_wdata = bus.p1_wdata;
        end
    end

    assign w_any         = w_gnt0 | w_gnt1;
    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_din   = (w_any && w_we) ? w_wdata : '0;
    assign bus.mem_rd_en = w_any && !w_we;
    assign bus.mem_wr_en = w_any && w_we;
    assign bus.p0_rvalid = r_p0_rvalid;
    assign bus.p1_rvalid = r_p1_rvalid;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;

    // State, lock run length and read-return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB;
            r_rr_last   <= 1'b1;
            r_lock_cnt  <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt0 && !w_we;
            r_p1_rvalid <= w_gnt1 && !w_we;
            if (w_gnt0 && !w_we) r_p0_rdata <= bus.mem_dout;
            if (w_gnt1 && !w_we) r_p1_rdata <= bus.mem_dout;
            if (w_any) begin
                r_rr_last <= w_gnt1;
                if (w_lock && (r_lock_cnt < LOCK_LIMIT)) begin
                    r_state    <= w_gnt0 ? LOCK0 : LOCK1;
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end else begin
                    r_state    <= ARB;
                    r_lock_cnt <= '0;
                end
            end else begin
                r_state    <= ARB;
                r_lock_cnt <= '0;
            end
        end
    end

`ifdef DAT_MEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    // Saturating count of cycles where both ports request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (bus.p0_req && bus.p1_req && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 16'd0;
`endif
endmodule
